// File: rtl/kf_seq.sv
// kf_seq: program-driven sequencer that fetches instructions and issues operations to kf_core.
// Each instruction runs as FETCH, ISSUE, WAIT for au_done, then WRITE, with a timeout on the wait.
module kf_seq #(
  parameter int W          = 24,
  parameter int ADDRW      = 3,
  parameter int PROG_DEPTH = 16,
  parameter int TIMEOUT    = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          prog_we,
  input  logic [$clog2(PROG_DEPTH)-1:0] prog_addr,
  input  logic [5+3*ADDRW-1:0]          prog_data,
  input  logic                          start,
  input  logic                          au_done,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  output logic [$clog2(PROG_DEPTH)-1:0] pc,
  output logic [ADDRW-1:0]              CTL_A,
  output logic [ADDRW-1:0]              CTL_B,
  output logic                          sel_dira,
  output logic                          sel_dirb,
  output logic [1:0]                    op_sel,
  output logic [1:0]                    mul_y_sel,
  output logic                          au_start,
  output logic                          WRITE_REQ,
  output logic                          READY_G,
  output logic [1:0]                    sel_data,
  output logic [1:0]                    sel_write,
  output logic [ADDRW-1:0]              DB_WADDR
);
  localparam int PCW = $clog2(PROG_DEPTH);
  localparam int IW  = 5 + 3*ADDRW;
  localparam int CW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_WRITE, S_DONE} state_t;

  // W sizes only the kf_core datapath; the sequencer itself never carries data words.
  if (W < 1) begin : g_w_check
  end

  state_t          r_state;
  logic [IW-1:0]   r_prog [PROG_DEPTH];
  logic [IW-1:0]   r_ir;
  logic [PCW-1:0]  r_pc;
  logic [CW-1:0]   r_cnt;
  logic            r_err;
  logic            r_done;
  logic            r_au_start;
  logic            r_wr;
  logic [IW-1:0]   w_ins;

  assign w_ins = r_prog[r_pc];

  always_ff @(posedge clk)
    if (prog_we && !busy) r_prog[prog_addr] <= prog_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_ir       <= '0;
      r_pc       <= '0;
      r_cnt      <= '0;
      r_err      <= 1'b0;
      r_done     <= 1'b0;
      r_au_start <= 1'b0;
      r_wr       <= 1'b0;
    end else begin
      r_au_start <= 1'b0;
      r_done     <= 1'b0;
      r_wr       <= 1'b0;
      case (r_state)
        S_IDLE: if (start) begin
          r_pc    <= '0;
          r_err   <= 1'b0;
          r_state <= S_FETCH;
        end
        S_FETCH: begin
          r_ir       <= w_ins;
          r_cnt      <= '0;
          r_au_start <= 1'b1;
          r_state    <= S_ISSUE;
        end
        S_ISSUE: r_state <= S_WAIT;
        S_WAIT: if (au_done) begin
          r_wr    <= 1'b1;
          r_state <= S_WRITE;
        end else if (r_cnt == CW'(TIMEOUT-1)) begin
          r_err   <= 1'b1;
          r_state <= S_IDLE;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
        // the last slot always terminates so pc never wraps back to 0 within a run
        S_WRITE: if (r_ir[IW-1] || r_pc == PCW'(PROG_DEPTH-1)) begin
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end else begin
          r_pc    <= r_pc + 1'b1;
          r_state <= S_FETCH;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy      = r_state != S_IDLE;
  assign done      = r_done;
  assign err       = r_err;
  assign pc        = r_pc;
  assign au_start  = r_au_start;
  assign op_sel    = r_ir[IW-2 -: 2];
  assign mul_y_sel = r_ir[IW-4 -: 2];
  assign CTL_A     = r_ir[3*ADDRW-1 -: ADDRW];
  assign CTL_B     = r_ir[2*ADDRW-1 -: ADDRW];
  assign DB_WADDR  = r_ir[ADDRW-1:0];
  assign sel_dira  = 1'b0;
  assign sel_dirb  = 1'b0;
  assign WRITE_REQ = r_wr;
  assign READY_G   = r_wr;
  assign sel_data  = {1'b0, r_wr};
  assign sel_write = {1'b0, r_wr};
endmodule

// File: tb/tb_kf_seq.sv
// tb_kf_seq: table vectors, directed corner cases and randomized programs checked against a timing model.
module tb_kf_seq;
  typedef struct packed {
    logic       last;
    logic [1:0] op;
    logic [1:0] ys;
    logic [2:0] a;
    logic [2:0] b;
    logic [2:0] d;
  } instr_t;
  typedef struct {int cyc; int a; int b; int w; int op; int ys; int sd; int sw; int rg;} wr_t;
  typedef struct {instr_t ins; int dly; int wcyc; int dcyc; int ea; int eb; int ew; int eop; int eys;} vec_t;

  logic        clk = 1'b0, rst_n = 1'b0, prog_we = 1'b0, start = 1'b0, au_done = 1'b0;
  logic [3:0]  prog_addr = '0;
  logic [13:0] prog_data = '0;
  logic        busy, done, err, sel_dira, sel_dirb, au_start, WRITE_REQ, READY_G;
  logic [3:0]  pc;
  logic [2:0]  CTL_A, CTL_B, DB_WADDR;
  logic [1:0]  op_sel, mul_y_sel, sel_data, sel_write;
  logic [28:0] all_o;

  int     checks = 0, errors = 0;
  instr_t m_prog [16];
  int     g_delay [16];
  wr_t    wrs [$];
  int     n_start, done_cyc, done_pc, end_cyc, err1;
  bit     stab_bad, side_bad;
  vec_t   tv [4];

  kf_seq #(.W(24), .ADDRW(3), .PROG_DEPTH(16), .TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .start(start), .au_done(au_done), .busy(busy), .done(done), .err(err), .pc(pc),
    .CTL_A(CTL_A), .CTL_B(CTL_B), .sel_dira(sel_dira), .sel_dirb(sel_dirb), .op_sel(op_sel),
    .mul_y_sel(mul_y_sel), .au_start(au_start), .WRITE_REQ(WRITE_REQ), .READY_G(READY_G),
    .sel_data(sel_data), .sel_write(sel_write), .DB_WADDR(DB_WADDR)
  );

  assign all_o = {busy, done, err, pc, CTL_A, CTL_B, sel_dira, sel_dirb, op_sel, mul_y_sel,
                  au_start, WRITE_REQ, READY_G, sel_data, sel_write, DB_WADDR};

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int a, input instr_t ins);
    prog_we   = 1'b1;
    prog_addr = 4'(a);
    prog_data = ins;
    tick();
    prog_we   = 1'b0;
    m_prog[a] = ins;
  endtask

  // Starts a run, answers each au_start after g_delay cycles and records what the DUT does.
  task automatic run(input bit disturb, input bit coinc);
    int         rem = 0;
    int         cyc;
    bit         trk = 0;
    logic [12:0] snap = '0;
    wr_t        w;
    wrs.delete();
    n_start = 0; done_cyc = -1; done_pc = -1; end_cyc = -1; stab_bad = 0; side_bad = 0;
    start = 1'b1;
    if (coinc) begin
      prog_we   = 1'b1;
      prog_addr = 4'd0;
      prog_data = m_prog[0];
    end
    tick();
    start = 1'b0; prog_we = 1'b0; cyc = 1; err1 = int'(err);
    while (cyc < 400) begin
      if (au_start) begin
        n_start++;
        snap = {CTL_A, CTL_B, op_sel, mul_y_sel, DB_WADDR};
        trk  = 1;
      end else if (trk && snap != {CTL_A, CTL_B, op_sel, mul_y_sel, DB_WADDR}) stab_bad = 1;
      if (WRITE_REQ) begin
        w.cyc = cyc; w.a = int'(CTL_A); w.b = int'(CTL_B); w.w = int'(DB_WADDR);
        w.op = int'(op_sel); w.ys = int'(mul_y_sel); w.sd = int'(sel_data);
        w.sw = int'(sel_write); w.rg = int'(READY_G);
        wrs.push_back(w);
        trk = 0;
      end else if (READY_G || sel_data != 0 || sel_write != 0) side_bad = 1;
      if (sel_dira || sel_dirb) side_bad = 1;
      if (done) begin
        done_cyc = cyc;
        done_pc  = int'(pc);
        break;
      end
      if (!busy) begin
        end_cyc = cyc;
        break;
      end
      au_done = 1'b0;
      if (rem > 0) begin
        rem--;
        au_done = (rem == 0);
      end
      if (au_start) rem = g_delay[n_start-1] + 1;
      if (disturb) begin
        prog_we   = 1'b1;
        prog_addr = 4'($urandom_range(15));
        prog_data = 14'($urandom);
        start     = 1'b1;
      end
      tick();
      cyc++;
    end
    chk("run_bounded", int'(cyc < 400), 1);
    au_done = 1'b0; prog_we = 1'b0; start = 1'b0;
    tick();
  endtask

  // Expected behaviour from the latency rule: each instruction is 4 + delay cycles, done one cycle after the last write.
  task automatic expect_check(input string nm);
    int     t = 1;
    int     n = 0;
    instr_t ins;
    for (int i = 0; i < 16; i++) begin
      ins = m_prog[i];
      if (n < wrs.size()) begin
        chk({nm, "_wcyc"}, wrs[n].cyc, t + 3 + g_delay[i]);
        chk({nm, "_waddr"}, wrs[n].w, int'(ins.d));
        chk({nm, "_ctla"}, wrs[n].a, int'(ins.a));
        chk({nm, "_ctlb"}, wrs[n].b, int'(ins.b));
        chk({nm, "_op"}, wrs[n].op, int'(ins.op));
        chk({nm, "_ysel"}, wrs[n].ys, int'(ins.ys));
        chk({nm, "_wqual"}, wrs[n].sd * 100 + wrs[n].sw * 10 + wrs[n].rg, 111);
      end
      t += 4 + g_delay[i];
      n++;
      if (ins.last || i == 15) break;
    end
    chk({nm, "_nwrites"}, wrs.size(), n);
    chk({nm, "_nstart"}, n_start, n);
    chk({nm, "_done_cyc"}, done_cyc, t);
    chk({nm, "_done_pc"}, done_pc, n - 1);
    chk({nm, "_err"}, int'(err), 0);
    chk({nm, "_stable"}, int'(stab_bad), 0);
    chk({nm, "_side"}, int'(side_bad), 0);
  endtask

  initial begin
    int          act;
    logic [13:0] r;
    instr_t      ins;

    tv[0] = '{'{1'b1, 2'd0, 2'd0, 3'd0, 3'd1, 3'd2}, 0, 4, 5, 0, 1, 2, 0, 0};
    tv[1] = '{'{1'b1, 2'd3, 2'd2, 3'd5, 3'd6, 3'd7}, 20, 24, 25, 5, 6, 7, 3, 2};
    tv[2] = '{'{1'b1, 2'd1, 2'd1, 3'd7, 3'd0, 3'd4}, 3, 7, 8, 7, 0, 4, 1, 1};
    tv[3] = '{'{1'b1, 2'd2, 2'd3, 3'd3, 3'd3, 3'd0}, 1, 5, 6, 3, 3, 0, 2, 3};
    for (int i = 0; i < 16; i++) g_delay[i] = 0;

    #1;
    chk("reset_outputs", int'(all_o), 0);
    @(posedge clk); @(posedge clk); #1;
    chk("reset_held", int'(all_o), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      r = 14'($urandom);
      load(i, instr_t'(r));
    end

    for (int i = 0; i < 4; i++) begin
      load(0, tv[i].ins);
      g_delay[0] = tv[i].dly;
      run(0, 0);
      chk("tv_nwrites", wrs.size(), 1);
      if (wrs.size() > 0) begin
        chk("tv_wcyc", wrs[0].cyc, tv[i].wcyc);
        chk("tv_ctla", wrs[0].a, tv[i].ea);
        chk("tv_ctlb", wrs[0].b, tv[i].eb);
        chk("tv_waddr", wrs[0].w, tv[i].ew);
        chk("tv_op", wrs[0].op, tv[i].eop);
        chk("tv_ysel", wrs[0].ys, tv[i].eys);
      end
      chk("tv_dcyc", done_cyc, tv[i].dcyc);
      chk("tv_nstart", n_start, 1);
      chk("tv_stable", int'(stab_bad), 0);
    end

    load(0, '{1'b0, 2'd0, 2'd0, 3'd0, 3'd1, 3'd2});
    load(1, '{1'b1, 2'd1, 2'd0, 3'd0, 3'd1, 3'd3});
    g_delay[0] = 0; g_delay[1] = 0;
    run(0, 0);
    chk("two_dcyc", done_cyc, 9);
    chk("two_nstart", n_start, 2);
    if (wrs.size() == 2) begin
      chk("two_w0", wrs[0].cyc * 10 + wrs[0].w, 42);
      chk("two_w1", wrs[1].cyc * 10 + wrs[1].w, 83);
    end else chk("two_nwrites", wrs.size(), 2);
    expect_check("two");

    load(0, '{1'b1, 2'd0, 2'd0, 3'd1, 3'd2, 3'd3});
    g_delay[0] = 1000;
    run(0, 0);
    chk("to_end_cyc", end_cyc, 67);
    chk("to_err", int'(err), 1);
    chk("to_busy", int'(busy), 0);
    chk("to_nwrites", wrs.size(), 0);
    chk("to_done", done_cyc, -1);
    g_delay[0] = 0;
    run(0, 0);
    chk("to_err_cleared", err1, 0);
    expect_check("after_to");

    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < 16; i++) begin
        r   = 14'($urandom);
        ins = instr_t'(r);
        ins.last = (it == 0) ? 1'b0 : ($urandom_range(4) == 0);
        load(i, ins);
        g_delay[i] = (it == 0) ? 0 : int'($urandom_range(4));
      end
      run(0, 0);
      if (it == 0) begin
        chk("nolast_dcyc", done_cyc, 65);
        chk("nolast_pc", done_pc, 15);
      end
      expect_check("rand");
    end

    load(0, '{1'b1, 2'd0, 2'd0, 3'd1, 3'd1, 3'd5});
    m_prog[0] = '{1'b1, 2'd2, 2'd1, 3'd2, 3'd3, 3'd6};
    g_delay[0] = 0;
    run(0, 1);
    expect_check("coinc");

    load(0, '{1'b0, 2'd1, 2'd2, 3'd4, 3'd5, 3'd6});
    load(1, '{1'b0, 2'd2, 2'd3, 3'd7, 3'd1, 3'd0});
    load(2, '{1'b1, 2'd3, 2'd0, 3'd2, 3'd6, 3'd1});
    for (int i = 0; i < 3; i++) g_delay[i] = int'($urandom_range(3));
    run(1, 0);
    expect_check("disturb");
    run(0, 0);
    expect_check("readback");

    load(0, '{1'b0, 2'd0, 2'd0, 3'd0, 3'd1, 3'd2});
    load(1, '{1'b1, 2'd1, 2'd0, 3'd0, 3'd1, 3'd3});
    g_delay[0] = 0; g_delay[1] = 0;
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    au_done = 1'b1; tick(); au_done = 1'b0;
    tick(); tick(); tick();
    chk("rst_pre_pc", int'(pc), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async", int'(all_o), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    act = 0;
    au_done = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      act += int'(WRITE_REQ) + int'(done) + int'(busy) + int'(au_start);
    end
    au_done = 1'b0;
    chk("rst_quiet", act, 0);
    run(0, 0);
    expect_check("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/kf_seq.md
KF_SEQ -- requirements
Module: kf_seq

Interface
REQ-001 Parameter W, default 24, datapath word width of the downstream kf_core.
REQ-002 Parameter ADDRW, default 3, data-bank address width.
REQ-003 Parameter PROG_DEPTH, default 16, number of instruction slots; PCW = clog2(PROG_DEPTH).
REQ-004 Parameter TIMEOUT, default 64, maximum cycles spent waiting for au_done.
REQ-005 Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- prog_we  in  1  program write strobe.
- prog_addr  in  PCW  program slot address.
- prog_data  in  IW = 5+3*ADDRW  instruction, packed as {last, op[1:0], ysel[1:0], srcA, srcB, dst}.
- start  in  1  start-program pulse.
- au_done  in  1  operation-complete strobe from kf_core.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the program completes.
- err  out  1  sticky timeout flag.
- pc  out  PCW  current instruction index.
- CTL_A, CTL_B  out  ADDRW  kf_core read addresses.
- sel_dira, sel_dirb  out  1  kf_core read-address source selects.
- op_sel, mul_y_sel  out  2  kf_core operation and multiply-Y selects.
- au_start  out  1  kf_core operation start pulse.
- WRITE_REQ, READY_G  out  1  kf_core write request and write gate.
- sel_data, sel_write  out  2  kf_core write-data and write-mode selects.
- DB_WADDR  out  ADDRW  kf_core write address.

Function
REQ-006 The block SHALL hold PROG_DEPTH x IW program registers, written on clk when prog_we=1 and busy=0; a write while busy=1 SHALL be ignored.
REQ-007 The FSM SHALL have the states IDLE, FETCH, ISSUE, WAIT, WRITE and DONE.
REQ-008 IDLE, start=1: the block SHALL set pc=0 and go to FETCH; start in any other state SHALL be ignored.
REQ-009 FETCH: the block SHALL latch program[pc] into the instruction register and register CTL_A=srcA, CTL_B=srcB, op_sel=op, mul_y_sel=ysel, DB_WADDR=dst, then go to ISSUE.
REQ-010 ISSUE: au_start SHALL be 1 for exactly this cycle, and the block SHALL go to WAIT.
REQ-011 CTL_A, CTL_B, op_sel, mul_y_sel and DB_WADDR SHALL stay stable from ISSUE through WRITE.
REQ-012 WAIT: the block SHALL sample au_done each cycle.
- au_done=1: go to WRITE.
- Otherwise: increment a wait counter.
- Counter reaches TIMEOUT-1 with au_done=0: set err=1 and go to IDLE with no write and no done pulse.
REQ-013 WRITE: WRITE_REQ=1, READY_G=1, sel_data=1 (RESULT) and sel_write=1 (gated write) SHALL all be asserted for exactly one cycle.
REQ-014 After WRITE, if last=1 or pc=PROG_DEPTH-1, the block SHALL go to DONE; otherwise it SHALL increment pc and go to FETCH. pc SHALL never wrap to 0 within a run.
REQ-015 DONE: done=1 for exactly one cycle, then go to IDLE; pc SHALL hold its final value.
REQ-016 sel_dira and sel_dirb SHALL be constant 0 (CTL source). Outside WRITE, WRITE_REQ, READY_G, sel_data and sel_write SHALL be 0.
REQ-017 Latency: each non-timed-out instruction SHALL take exactly 4 + k cycles (FETCH, ISSUE, WAIT, WRITE), where k is the number of extra WAIT cycles.
- A run where au_done arrives in the first WAIT cycle SHALL take N*4+1 cycles from start to the done pulse.
REQ-018 An au_done arriving outside WAIT SHALL be ignored.
REQ-019 err SHALL clear only when start is accepted in IDLE or on reset.
REQ-020 A start pulse coincident with prog_we in IDLE SHALL both write the program and start execution; the run SHALL fetch the updated contents when the written slot is fetched.

Reset
REQ-021 rst_n=0 SHALL immediately force, independent of clk:
- State: IDLE; pc=0.
- Handshake: busy=0, done=0, err=0.
- kf_core drives: all kf_core control outputs 0.
- Counter: wait counter 0.
REQ-022 Program registers SHALL NOT be reset.
REQ-023 Reset asserted mid-run SHALL abort the run with no write pulse and no done pulse after release.

Verification
REQ-024 Program {last=0, op=ADD, srcA=0, srcB=1, dst=2}, {last=1, op=SUB, srcA=0, srcB=1, dst=3}; start; au_done returned one cycle after each au_start -> two au_start pulses, WRITE pulses with DB_WADDR=2 then 3, done on cycle 9 after start, err=0.
REQ-025 Single DIV instruction (op=3, ysel=2) with au_done delayed 20 cycles -> WRITE asserted only the cycle after au_done, with CTL_A and CTL_B stable throughout.
REQ-026 au_done never returned, TIMEOUT=64 -> err=1 after 64 WAIT cycles, busy=0, no WRITE_REQ and no done; a following start clears err.
REQ-027 No last bit in any of 16 slots -> the run executes all 16 instructions, then done with pc=15, and no wrap.
REQ-028 rst_n pulsed low during WAIT of instruction 1 -> all outputs 0 asynchronously, and no write or done after release.
REQ-029 prog_we during a run, and start during a run -> program unchanged and start ignored, confirmed by a readback run.
